// File: rtl/axi_write_data_burst_channel.sv
// AXI write-data channel master with a small beat buffer.
// A burst descriptor (ID, beats-1) is captured on go. Source beats with byte
// strobes are queued in a FIFO and presented on W, with WLAST derived from an
// internal beat counter. done stays high until go is released.
module axi_write_data_burst_channel #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      go,
    input  logic [LEN_WIDTH-1:0]      burst_len,
    input  logic [ID_WIDTH-1:0]       transaction_id,
    input  logic [DATA_WIDTH-1:0]     data,
    input  logic [DATA_WIDTH/8-1:0]   strb,
    input  logic                      data_valid,
    output logic                      data_ready,
    output logic                      done,
    output logic [ID_WIDTH-1:0]       WID,
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      WLAST,
    output logic                      WVALID,
    input  logic                      WREADY,
    output logic [LEN_WIDTH:0]        beat_count,
    output logic [1:0]                current_state_out
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUNNING  = 2'b01,
        COMPLETE = 2'b10
    } state_t;

    state_t state;
    state_t next_state;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [ID_WIDTH-1:0]   wid_q;
    logic [LEN_WIDTH:0]    in_count;
    logic [LEN_WIDTH:0]    beat_cnt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [STRB_WIDTH-1:0] strb_mem [FIFO_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic start;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                        (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    assign WID               = wid_q;
    assign beat_count        = beat_cnt;
    assign current_state_out = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus handshakes and W outputs; W is only live while running.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        data_ready = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        WVALID     = 1'b0;
        WLAST      = 1'b0;
        WDATA      = '0;
        WSTRB      = '0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    start      = 1'b1;
                    next_state = RUNNING;
                end
            end
            RUNNING: begin
                data_ready = !fifo_full && (in_count <= {1'b0, len_q});
                push       = data_valid && data_ready;
                WVALID     = !fifo_empty;
                if (WVALID) begin
                    WDATA = data_mem[rd_ptr[ADDR_WIDTH-1:0]];
                    WSTRB = strb_mem[rd_ptr[ADDR_WIDTH-1:0]];
                end
                WLAST = WVALID && (beat_cnt == {1'b0, len_q});
                pop   = WVALID && WREADY;
                if (pop && WLAST) begin
                    next_state = COMPLETE;
                end
            end
            COMPLETE: begin
                done = 1'b1;
                if (!go) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Descriptor capture, beat counters and FIFO pointers; a new burst starts with an empty FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q    <= '0;
            wid_q    <= '0;
            in_count <= '0;
            beat_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (start) begin
            len_q    <= burst_len;
            wid_q    <= transaction_id;
            in_count <= '0;
            beat_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                in_count <= in_count + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state == COMPLETE && !go) begin
                wid_q <= '0;
            end
        end
    end

    // Beat storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr[ADDR_WIDTH-1:0]] <= data;
            strb_mem[wr_ptr[ADDR_WIDTH-1:0]] <= strb;
        end
    end

endmodule

// File: tb/tb_axi_write_data_burst_channel.sv
// Scoreboard bench for axi_write_data_burst_channel: each burst pushes its
// expected W beats up front, and a monitor pops them as W handshakes occur.
module tb_axi_write_data_burst_channel;

    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int LEN_WIDTH  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  go;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic [ID_WIDTH-1:0]   transaction_id;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  data_valid;
    logic                  data_ready;
    logic                  done;
    logic [ID_WIDTH-1:0]   WID;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    logic [LEN_WIDTH:0]    beat_count;
    logic [1:0]            current_state_out;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
    } expBeat_t;

    expBeat_t expQ[$];
    expBeat_t headBeat;
    int       checks    = 0;
    int       errors    = 0;
    int       popCount  = 0;
    bit       monitorOn = 1'b0;

    axi_write_data_burst_channel #(
        .DATA_WIDTH(DATA_WIDTH),
        .ID_WIDTH  (ID_WIDTH),
        .LEN_WIDTH (LEN_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .go               (go),
        .burst_len        (burst_len),
        .transaction_id   (transaction_id),
        .data             (data),
        .strb             (strb),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .done             (done),
        .WID              (WID),
        .WDATA            (WDATA),
        .WSTRB            (WSTRB),
        .WLAST            (WLAST),
        .WVALID           (WVALID),
        .WREADY           (WREADY),
        .beat_count       (beat_count),
        .current_state_out(current_state_out)
    );

    always #5 clk = ~clk;

    // Global safety net so the run can never hang.
    initial begin
        #5000000;
        $display("[TB] FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "[TB] global timeout");
    end

    // W-side monitor: pops the scoreboard on each handshake, checks head stability
    // while stalled, and checks W payload is zero whenever WVALID is low.
    always @(negedge clk) begin
        if (monitorOn) begin
            if (WVALID && WREADY) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got WDATA=%h WLAST=%b, required no beat", WDATA, WLAST);
                end else begin
                    headBeat = expQ.pop_front();
                    popCount++;
                    if (WDATA !== headBeat.data || WSTRB !== headBeat.strb ||
                        WLAST !== headBeat.last || WID !== headBeat.id) begin
                        errors++;
                        $display("[TB] FAIL w_beat: got data=%h strb=%h last=%b id=%h, required data=%h strb=%h last=%b id=%h",
                                 WDATA, WSTRB, WLAST, WID, headBeat.data, headBeat.strb, headBeat.last, headBeat.id);
                    end
                end
            end else if (WVALID) begin
                if (expQ.size() > 0) begin
                    checks++;
                    if (WDATA !== expQ[0].data || WSTRB !== expQ[0].strb) begin
                        errors++;
                        $display("[TB] FAIL stall_stability: got data=%h strb=%h, required data=%h strb=%h",
                                 WDATA, WSTRB, expQ[0].data, expQ[0].strb);
                    end
                end
            end else begin
                checks++;
                if (WDATA !== '0 || WSTRB !== '0 || WLAST !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL idle_zero: got data=%h strb=%h last=%b, required all zero", WDATA, WSTRB, WLAST);
                end
            end
        end
    end

    // Single comparison with reporting.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    // Drive one complete burst from go to the return to IDLE. Entered and left at posedge+1.
    // mode: 0 random data/strb, 1 data=i+1 strb=F, 2 data=i+1 strb pattern 1,3,8,0, 3 A5A5A5A5/F.
    task automatic applyStimulus(input int len, input int id, input int mode, input int extra,
                                 input int validPct, input int readyPct, input int stallCycles);
        logic [DATA_WIDTH-1:0] bd[$];
        logic [STRB_WIDTH-1:0] bs[$];
        logic [DATA_WIDTH-1:0] d;
        logic [STRB_WIDTH-1:0] s;
        int n, srcIdx, accepted, cyc, budget, fillExp;
        bit finished;

        n = len + 1 + extra;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: begin d = $urandom; s = STRB_WIDTH'($urandom_range(0, 15)); end
                1: begin d = DATA_WIDTH'(i + 1); s = 4'hF; end
                2: begin
                    d = DATA_WIDTH'(i + 1);
                    case (i % 4)
                        0: s = 4'h1;
                        1: s = 4'h3;
                        2: s = 4'h8;
                        default: s = 4'h0;
                    endcase
                end
                default: begin d = 32'hA5A5A5A5; s = 4'hF; end
            endcase
            bd.push_back(d);
            bs.push_back(s);
        end
        for (int i = 0; i <= len; i++) begin
            expQ.push_back('{data: bd[i], strb: bs[i], last: (i == len), id: ID_WIDTH'(id)});
        end

        go             = 1'b1;
        burst_len      = LEN_WIDTH'(len);
        transaction_id = ID_WIDTH'(id);
        srcIdx   = 0;
        accepted = 0;
        cyc      = 0;
        finished = 1'b0;
        budget   = 30 * (len + 1) + stallCycles + 60;
        fillExp  = (len + 1 < FIFO_DEPTH) ? len + 1 : FIFO_DEPTH;

        while (!finished && cyc < budget) begin
            if (srcIdx < n) begin
                data_valid = ($urandom_range(0, 99) < validPct);
                data       = bd[srcIdx];
                strb       = bs[srcIdx];
            end else begin
                data_valid = 1'b0;
                data       = '0;
                strb       = '0;
            end
            WREADY = (cyc >= stallCycles) && ($urandom_range(0, 99) < readyPct);
            @(negedge clk);
            if (data_valid && data_ready) begin
                srcIdx++;
                accepted++;
            end
            if (stallCycles > 0 && validPct == 100 && cyc == stallCycles - 1) begin
                checkOutput("stall_fill_count", 64'(accepted), 64'(fillExp));
                checkOutput("stall_data_ready", 64'(data_ready), 64'd0);
            end
            if (done) finished = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end

        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL burst_timeout: no done after %0d cycles, required done for len=%0d", budget, len);
            reset = 1'b1;
            go = 1'b0; data_valid = 1'b0; WREADY = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            expQ.delete();
            return;
        end

        checkOutput("complete_state", 64'(current_state_out), 64'd2);
        checkOutput("complete_wvalid", 64'(WVALID), 64'd0);
        checkOutput("complete_data_ready", 64'(data_ready), 64'd0);
        checkOutput("complete_wid", 64'(WID), 64'(id));
        checkOutput("final_beat_count", 64'(beat_count), 64'(len + 1));
        checkOutput("accepted_beats", 64'(accepted), 64'(len + 1));
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

        // go still high: must stay in COMPLETE, no restart.
        @(posedge clk); #1;
        checkOutput("hold_complete", 64'(current_state_out), 64'd2);
        checkOutput("hold_done", 64'(done), 64'd1);

        go = 1'b0; data_valid = 1'b0; WREADY = 1'b0;
        @(posedge clk); #1;
        checkOutput("back_idle_state", 64'(current_state_out), 64'd0);
        checkOutput("back_idle_wid", 64'(WID), 64'd0);
        checkOutput("back_idle_done", 64'(done), 64'd0);
        expQ.delete();
    endtask

    // Abort a 4-beat burst with reset after two W beats have transferred.
    task automatic applyResetMidBurst();
        int startPop, cyc, srcIdx;
        startPop = popCount;
        for (int i = 0; i < 4; i++) begin
            expQ.push_back('{data: DATA_WIDTH'(32'h100 + i), strb: 4'hF, last: (i == 3), id: 4'h9});
        end
        go = 1'b1; burst_len = 8'd3; transaction_id = 4'h9;
        srcIdx = 0;
        cyc = 0;
        while ((popCount - startPop) < 2 && cyc < 40) begin
            data_valid = (srcIdx < 4);
            data       = DATA_WIDTH'(32'h100 + srcIdx);
            strb       = 4'hF;
            WREADY     = 1'b1;
            @(negedge clk);
            if (data_valid && data_ready) srcIdx++;
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("reset_pre_pops", 64'(popCount - startPop), 64'd2);
        reset = 1'b1; go = 1'b0; data_valid = 1'b0; WREADY = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort_wvalid", 64'(WVALID), 64'd0);
        checkOutput("abort_data_ready", 64'(data_ready), 64'd0);
        checkOutput("abort_state", 64'(current_state_out), 64'd0);
        checkOutput("abort_wid", 64'(WID), 64'd0);
        checkOutput("abort_beat_count", 64'(beat_count), 64'd0);
        expQ.delete();
        @(posedge clk); #1;
        checkOutput("abort_stays_empty", 64'(WVALID), 64'd0);
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; burst_len = '0; transaction_id = '0;
        data = '0; strb = '0; data_valid = 1'b0; WREADY = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        monitorOn = 1'b1;
        checkOutput("reset_state", 64'(current_state_out), 64'd0);
        checkOutput("reset_wvalid", 64'(WVALID), 64'd0);
        checkOutput("reset_wlast", 64'(WLAST), 64'd0);
        checkOutput("reset_data_ready", 64'(data_ready), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_wid", 64'(WID), 64'd0);
        checkOutput("reset_beat_count", 64'(beat_count), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] single-beat burst");
        applyStimulus(0, 5, 3, 0, 100, 100, 0);
        $display("[TB] four-beat streaming burst");
        applyStimulus(3, 3, 1, 0, 100, 100, 0);
        $display("[TB] eight-beat burst with initial W stall");
        applyStimulus(7, 2, 1, 0, 100, 100, 10);
        $display("[TB] two-beat burst with surplus source beat");
        applyStimulus(1, 6, 1, 1, 100, 100, 0);
        $display("[TB] strobe pattern burst");
        applyStimulus(3, 1, 2, 0, 100, 100, 0);
        $display("[TB] reset in mid-burst then fresh burst");
        applyResetMidBurst();
        applyStimulus(3, 10, 0, 0, 70, 70, 0);

        $display("[TB] randomized bursts");
        for (int k = 0; k < 12; k++) begin
            applyStimulus($urandom_range(0, 12), $urandom_range(0, 15), 0, $urandom_range(0, 2),
                          $urandom_range(40, 100), $urandom_range(30, 100), 0);
        end

        $display("[TB] maximum-length burst");
        applyStimulus(255, 15, 0, 1, 100, 100, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
